// File: rtl/gpr_write_arbiter.sv
// Purpose : share the single GPR write port between the main writeback (R0) and
//           the mul/div unit (R1); track busy R1 destinations and stall decode.
// Latency : 1 cycle grant -> reg_write/num_write/data_write (0 with GPR_WB_BYPASS_EN).
// Backpres: wb_ready/md_ready combinational; R0 has fixed priority until R1 has
//           lost MD_STARVE_MAX contended cycles, then R1 is forced through once.
//
// Build option: `define GPR_WB_BYPASS_EN removes the output register stage.
//
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   wb_valid/wb_num/wb_data/wb_ready  R0 write request (main writeback)
//   md_valid/md_num/md_data/md_ready  R1 write request (mul/div unit)
//   reserve_valid/reserve_num         mul/div issue: mark destination busy
//   rs, rt / stall                    decode source registers / busy-hit stall
//   reg_write/num_write/data_write    to the GPR file write port
module gpr_write_arbiter #(
  parameter int NUM_REGS      = 32,
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 32,
  parameter int MD_STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_num,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_num,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_num,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              stall,
  output logic              reg_write,
  output logic [ADDR_W-1:0] num_write,
  output logic [DATA_W-1:0] data_write
);

  localparam int CNT_W = (MD_STARVE_MAX < 1) ? 1 : $clog2(MD_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_STARVE_MAX);

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_FORCE_MD = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    starve_cnt;
  logic [CNT_W-1:0]    starve_inc;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  logic                grant_wb;
  logic                grant_md;
  logic                grant_any;
  logic [ADDR_W-1:0]   grant_num;
  logic [DATA_W-1:0]   grant_data;

  // Scoreboard clear request, sourced differently per output-stage build
  logic                clr_valid;
  logic [ADDR_W-1:0]   clr_num;

  // ---------------------------------------------------------------------------
  // Grant selection. Nothing is granted while reset is high, so a requester
  // never sees ready during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_wb = 1'b0;
    grant_md = 1'b0;
    if (!reset) begin
      if (state == ST_FORCE_MD) begin
        if (md_valid)      grant_md = 1'b1;
        else if (wb_valid) grant_wb = 1'b1;
      end else begin
        if (wb_valid)      grant_wb = 1'b1;
        else if (md_valid) grant_md = 1'b1;
      end
    end
  end

  assign wb_ready   = grant_wb;
  assign md_ready   = grant_md;
  assign grant_any  = grant_wb | grant_md;
  assign grant_num  = grant_md ? md_num  : wb_num;
  assign grant_data = grant_md ? md_data : wb_data;
  assign starve_inc = starve_cnt + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Starvation FSM. The counter only moves on cycles where R1 lost to R0; the
  // edge that brings it to the limit also flips the state, so R1 wins on the
  // very next contended cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_NORMAL: begin
          if (grant_md) begin
            starve_cnt <= '0;
          end else if (wb_valid && md_valid) begin
            starve_cnt <= starve_inc;
            if (starve_inc == CNT_MAX) state <= ST_FORCE_MD;
          end
        end
        ST_FORCE_MD: begin
          // Counter holds at the limit while R1 is absent and R0 uses the port
          if (grant_md) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
          end
        end
        default: begin
          state      <= ST_NORMAL;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef GPR_WB_BYPASS_EN
  // Combinational path: outputs are zero whenever nothing is granted.
  assign reg_write  = grant_any && (grant_num != '0);
  assign num_write  = grant_any ? grant_num  : '0;
  assign data_write = grant_any ? grant_data : '0;

  // Busy bit clears at the handshake edge itself
  assign clr_valid  = grant_md && (md_num != '0);
  assign clr_num    = md_num;
`else
  // Remembers whether the write currently on the port came from R1; only
  // those writes retire a scoreboard entry.
  logic out_from_md;

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_write   <= 1'b0;
      num_write   <= '0;
      data_write  <= '0;
      out_from_md <= 1'b0;
    end else if (grant_any) begin
      // r0 writes consume their grant but never reach the register file
      reg_write   <= (grant_num != '0);
      num_write   <= grant_num;
      data_write  <= grant_data;
      out_from_md <= grant_md;
    end else begin
      reg_write   <= 1'b0;
      out_from_md <= 1'b0;
    end
  end

  // Busy bit clears on the same edge the GPR file captures the R1 data
  assign clr_valid = reg_write && out_from_md;
  assign clr_num   = num_write;
`endif

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Set is applied after clear so a same-edge re-reserve of a
  // retiring register keeps it busy.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_next = busy;
    if (clr_valid)                             busy_next[clr_num]     = 1'b0;
    if (reserve_valid && reserve_num != '0)    busy_next[reserve_num] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign stall = !reset && (((rs != '0) && busy[rs]) || ((rt != '0) && busy[rt]));

endmodule

// File: tb/tb_gpr_write_arbiter.sv
module tb_gpr_write_arbiter;

  localparam int MAXS = 4;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_num;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        md_valid;
  logic [4:0]  md_num;
  logic [31:0] md_data;
  logic        md_ready;
  logic        reserve_valid;
  logic [4:0]  reserve_num;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        stall;
  logic        reg_write;
  logic [4:0]  num_write;
  logic [31:0] data_write;

  int total = 0;
  int bad   = 0;

  // Reference model: lost-cycle count for R1, a busy set, and the value
  // the write port is expected to present.
  int        m_lost;
  bit        m_busy [32];
  bit        m_rw;
  bit [4:0]  m_nw;
  bit [31:0] m_dw;
  bit        m_from_md;

  gpr_write_arbiter #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .MD_STARVE_MAX(MAXS)
  ) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data), .wb_ready(wb_ready),
    .md_valid(md_valid), .md_num(md_num), .md_data(md_data), .md_ready(md_ready),
    .reserve_valid(reserve_valid), .reserve_num(reserve_num),
    .rs(rs), .rt(rt), .stall(stall),
    .reg_write(reg_write), .num_write(num_write), .data_write(data_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall();
    if (reset) return 1'b0;
    return (rs != 0 && m_busy[rs]) || (rt != 0 && m_busy[rt]);
  endfunction

  task automatic model_grant(output bit gw, output bit gm);
    gw = 1'b0;
    gm = 1'b0;
    if (!reset) begin
      // R1 is owed the port once it has lost MAXS contended cycles
      if (md_valid && (m_lost >= MAXS || !wb_valid)) gm = 1'b1;
      else if (wb_valid)                             gw = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_lost = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_rw = 1'b0; m_nw = '0; m_dw = '0; m_from_md = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic step();
    bit gw, gm;
    @(negedge clock);
    model_grant(gw, gm);
    chk("wb_ready",   {31'b0, wb_ready},  {31'b0, gw});
    chk("md_ready",   {31'b0, md_ready},  {31'b0, gm});
    chk("stall",      {31'b0, stall},     {31'b0, model_stall()});
    chk("reg_write",  {31'b0, reg_write}, {31'b0, m_rw});
    chk("num_write",  {27'b0, num_write}, {27'b0, m_nw});
    chk("data_write", data_write,         m_dw);
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (m_rw && m_from_md) m_busy[m_nw] = 1'b0;
      if (reserve_valid && reserve_num != 0) m_busy[reserve_num] = 1'b1;
      if (gm) m_lost = 0;
      else if (wb_valid && md_valid) m_lost++;
      if (gw || gm) begin
        m_nw      = gm ? md_num  : wb_num;
        m_dw      = gm ? md_data : wb_data;
        m_rw      = (m_nw != 0);
        m_from_md = gm;
      end else begin
        m_rw      = 1'b0;
        m_from_md = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_num = '0; wb_data = '0;
    md_valid = 1'b0; md_num = '0; md_data = '0;
    reserve_valid = 1'b0; reserve_num = '0;
    rs = '0; rt = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;

    // Reset state
    step();
    step();
    reset = 1'b0;
    step();

    // Single R0 write
    wb_valid = 1'b1; wb_num = 5'd5; wb_data = 32'hDEAD_BEEF;
    step();
    idle();
    chk("r0_single_rw",   {31'b0, reg_write}, 32'd1);
    chk("r0_single_num",  {27'b0, num_write}, 32'd5);
    chk("r0_single_data", data_write, 32'hDEAD_BEEF);
    step();

    // Contention: R0 wins 4 cycles, R1 the 5th, then R0 again
    for (int i = 0; i < 6; i++) begin
      wb_valid = 1'b1; wb_num = 5'(i + 1); wb_data = 32'(100 + i);
      md_valid = 1'b1; md_num = 5'd9;      md_data = 32'h99;
      step();
      chk("contention_winner", {27'b0, num_write}, (i == 4) ? 32'd9 : 32'(i + 1));
    end
    idle();
    step();
    step();

    // Scoreboard: reserve r7, stall on rs, clear via R1 write
    reserve_valid = 1'b1; reserve_num = 5'd7;
    step();
    reserve_valid = 1'b0; rs = 5'd7;
    step();
    chk("sb_stall_set", {31'b0, stall}, 32'd1);
    md_valid = 1'b1; md_num = 5'd7; md_data = 32'h12;
    step();
    md_valid = 1'b0;
    chk("sb_md_rw",     {31'b0, reg_write}, 32'd1);
    chk("sb_md_num",    {27'b0, num_write}, 32'd7);
    chk("sb_stall_hold", {31'b0, stall}, 32'd1);
    step();
    chk("sb_stall_clr", {31'b0, stall}, 32'd0);

    // Same-edge clear and re-reserve keeps r7 busy
    reserve_valid = 1'b1; reserve_num = 5'd7;
    step();
    reserve_valid = 1'b0;
    md_valid = 1'b1; md_num = 5'd7; md_data = 32'h34;
    step();
    md_valid = 1'b0;
    reserve_valid = 1'b1; reserve_num = 5'd7;
    step();
    reserve_valid = 1'b0;
    chk("sb_same_edge", {31'b0, stall}, 32'd1);
    md_valid = 1'b1; md_num = 5'd7; md_data = 32'h56;
    step();
    md_valid = 1'b0;
    step();
    step();

    // r0 handling
    rs = 5'd0; rt = 5'd0;
    reserve_valid = 1'b1; reserve_num = 5'd0;
    step();
    reserve_valid = 1'b0;
    chk("r0_no_stall", {31'b0, stall}, 32'd0);
    wb_valid = 1'b1; wb_num = 5'd0; wb_data = 32'h77;
    step();
    wb_valid = 1'b0;
    chk("r0_write_blocked", {31'b0, reg_write}, 32'd0);
    step();

    // Mid-operation reset with an R1 write pending in the output stage
    reserve_valid = 1'b1; reserve_num = 5'd3;
    step();
    reserve_valid = 1'b0; rt = 5'd3;
    md_valid = 1'b1; md_num = 5'd3; md_data = 32'hABCD;
    step();
    md_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_rw",    {31'b0, reg_write}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    idle();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 59) == 0);
      wb_valid      = 1'($urandom_range(0, 1));
      wb_num        = 5'($urandom_range(0, 7));
      wb_data       = 32'($urandom);
      md_valid      = 1'($urandom_range(0, 1));
      md_num        = 5'($urandom_range(0, 7));
      md_data       = 32'($urandom);
      reserve_valid = ($urandom_range(0, 3) == 0);
      reserve_num   = 5'($urandom_range(0, 7));
      rs            = 5'($urandom_range(0, 7));
      rt            = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
